uart_tx: RTL



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, word-length encoding and helpers.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic [1:0] DBITS_5 = 2'd0;
   localparam logic [1:0] DBITS_6 = 2'd1;
   localparam logic [1:0] DBITS_7 = 2'd2;
   localparam logic [1:0] DBITS_8 = 2'd3;

   // Word length in bits for a data_bits code (5..8).
   function automatic logic [3:0] data_len(input logic [1:0] dbits);
      return 4'd5 + {2'b00, dbits};
   endfunction

   // Mask selecting the bits actually sent for a data_bits code.
   function automatic logic [7:0] data_mask(input logic [1:0] dbits);
      return 8'hFF >> (2'd3 - dbits);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversampling baud ticks and flags the last tick of each bit period.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_bit_done
);

   localparam int CW = $clog2(OVERSAMPLE);

   logic [CW-1:0] cnt;

   // OVERSAMPLE is a power of two, so the counter wraps to 0 on bit_done.
   assign o_bit_done = i_tick && !i_clr && (cnt == CW'(OVERSAMPLE - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (i_clr)
         cnt <= '0;
      else if (i_tick)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer fed by a first-word-fall-through fifo.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_baud_tick,
   input  logic [WIDTH-1:0] i_fifo_data,
   input  logic             i_fifo_empty,
   output logic             o_fifo_rd,
   input  logic [1:0]       i_data_bits,
   input  logic             i_stop2,
   input  logic             i_parity_en,
   input  logic             i_parity_odd,
   output logic             o_tx,
   output logic             o_busy
);

   uart_state_e      state, state_n;
   logic [WIDTH-1:0] shift, shift_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [2:0]       last_idx;
   logic [1:0]       dbits_q;
   logic             stop2_q;
   logic             tx_q, tx_n;
   logic             busy_q;
   logic             pop;
   logic             bit_done;
   logic             timer_clr;

`ifdef UART_TX_PARITY_EN
   logic par_en_q;
   logic par_bit_q;
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = i_parity_en ^ i_parity_odd;
`endif

   assign timer_clr = (state == IDLE);
   assign last_idx  = 3'd4 + {1'b0, dbits_q};

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (timer_clr),
      .i_tick     (i_baud_tick),
      .o_bit_done (bit_done)
   );

   always_comb begin
      state_n   = state;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            // Gated by reset so no pop strobe leaks out while held in reset.
            if (!i_fifo_empty && i_rst_n) begin
               pop       = 1'b1;
               state_n   = START;
               shift_n   = i_fifo_data;
               bit_cnt_n = '0;
            end
         end
         START: if (bit_done) state_n = DATA;
         DATA: begin
            if (bit_done) begin
               shift_n = shift >> 1;
               if (bit_cnt == last_idx) begin
                  bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n   = par_en_q ? PARITY : STOP;
`else
                  state_n   = STOP;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_done) state_n = STOP;
`endif
         STOP: begin
            if (bit_done) begin
               if (stop2_q && (bit_cnt == 3'd0)) begin
                  bit_cnt_n = 3'd1;
               end else begin
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level is registered from the next state so it changes with the state.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         START:  tx_n = 1'b0;
         DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_n = par_bit_q;
`endif
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         dbits_q   <= DBITS_5;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         shift   <= shift_n;
         bit_cnt <= bit_cnt_n;
         tx_q    <= tx_n;
         busy_q  <= (state_n != IDLE);
         if (pop) begin
            dbits_q   <= i_data_bits;
            stop2_q   <= i_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= i_parity_en;
            par_bit_q <= (^(i_fifo_data & data_mask(i_data_bits))) ^ i_parity_odd;
`endif
         end
      end
   end

   assign o_fifo_rd = pop;
   assign o_tx      = tx_q;
   assign o_busy    = busy_q;

endmodule
